shreg_ctrl: RTL and testbench

- Sequencer for the team's 8-bit parallel-load shift register (mode select: 00 load, 01 shift right, 10 shift left, 11 hold).
- Accepts a parallel word over a valid/ready handshake and drives the register's mode, parallel data and fill bit to serialise the word.
- Each bit is presented for a programmable number of clocks, LSB-first or MSB-first.
- Sits between a producer and the shift register instance; the register's q is fed back to source the serial output.

---
 rtl/shreg_ctrl_pkg.sv | 21 ++
 rtl/shreg_bit_timer.sv | 39 +++
 rtl/shreg_ctrl.sv | 166 ++++++++++++++++
 tb/tb_shreg_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/shreg_ctrl_pkg.sv
// Shared types and constants for the shift-register sequencer.
// The PARITY state exists only when SHREG_CTRL_PARITY_EN is defined.
package shreg_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
`ifdef SHREG_CTRL_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_DONE   = 3'd4
  } state_e;

  // Mode select codes understood by the parallel-load shift register
  localparam logic [1:0] SEL_LOAD = 2'b00;
  localparam logic [1:0] SEL_SHR  = 2'b01;
  localparam logic [1:0] SEL_SHL  = 2'b10;
  localparam logic [1:0] SEL_HOLD = 2'b11;

endpackage

// File: rtl/shreg_bit_timer.sv
// Per-bit dwell timer: counts 0..CLKS_PER_BIT-1 while enabled and flags
// the final clock of each bit period.
module shreg_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic last_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] tick_cnt_q, tick_cnt_d;

  assign last_tick = enable && (tick_cnt_q == TICK_LAST);

  // Advance the tick counter, wrapping to zero after the last tick
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (clear) begin
      tick_cnt_d = '0;
    end else if (enable) begin
      tick_cnt_d = last_tick ? '0 : tick_cnt_q + 1'b1;
    end
  end

  // Tick counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/shreg_ctrl.sv
// Sequencer that loads a word into an external parallel-load shift
// register and walks it out one bit per CLKS_PER_BIT clocks.
// Optional trailing even-parity bit: define SHREG_CTRL_PARITY_EN.
//
// state  | meaning
// IDLE   | ready for a word, register held
// LOAD   | parallel-load captured word into the register
// SHIFT  | present register end bit, shift on last tick of each bit
// PARITY | present parity of captured word (SHREG_CTRL_PARITY_EN only)
// DONE   | one-cycle completion pulse, not accepting
module shreg_ctrl #(
  parameter int   WIDTH        = 8,
  parameter int   CLKS_PER_BIT = 4,
  parameter logic FILL         = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic [1:0]       sr_s,
  output logic [WIDTH-1:0] sr_a,
  output logic             sr_shift_in,
  input  logic [WIDTH-1:0] sr_q,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);
  import shreg_ctrl_pkg::*;

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             msb_q, msb_d;
  logic             last_tick;
  logic             tmr_enable;
  logic             tmr_clear;
  logic             unused_sr_q;
`ifdef SHREG_CTRL_PARITY_EN
  logic             parity_q, parity_d;
`endif

  // Only the two end bits of the register feed the serial output
  assign unused_sr_q = ^sr_q;

`ifdef SHREG_CTRL_PARITY_EN
  assign tmr_enable = (state_q == ST_SHIFT) || (state_q == ST_PARITY);
`else
  assign tmr_enable = (state_q == ST_SHIFT);
`endif
  assign tmr_clear  = (state_q == ST_LOAD);

  shreg_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (tmr_clear),
    .enable   (tmr_enable),
    .last_tick(last_tick)
  );

  // Next-state and capture logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    msb_d     = msb_q;
`ifdef SHREG_CTRL_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          msb_d   = in_msb_first;
`ifdef SHREG_CTRL_PARITY_EN
          parity_d = ^in_data;
`endif
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (last_tick) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
`ifdef SHREG_CTRL_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
`ifdef SHREG_CTRL_PARITY_EN
      ST_PARITY: begin
        if (last_tick) state_d = ST_DONE;
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-word registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      data_q    <= '0;
      msb_q     <= 1'b0;
`ifdef SHREG_CTRL_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      msb_q     <= msb_d;
`ifdef SHREG_CTRL_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  // Output decode from registered state only
  always_comb begin
    in_ready  = 1'b0;
    sr_s      = SEL_HOLD;
    sr_a      = '0;
    ser_out   = 1'b0;
    ser_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: in_ready = 1'b1;
      ST_LOAD: begin
        sr_s = SEL_LOAD;
        sr_a = data_q;
      end
      ST_SHIFT: begin
        ser_valid = 1'b1;
        ser_out   = msb_q ? sr_q[WIDTH-1] : sr_q[0];
        if (last_tick) sr_s = msb_q ? SEL_SHL : SEL_SHR;
      end
`ifdef SHREG_CTRL_PARITY_EN
      ST_PARITY: begin
        ser_valid = 1'b1;
        ser_out   = parity_q;
      end
`endif
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign sr_shift_in = FILL;

endmodule

// File: tb/tb_shreg_ctrl.sv
// Bench for shreg_ctrl: two instances (CLKS_PER_BIT=4 and =1), each driving
// a behavioural shift register. Honours SHREG_CTRL_PARITY_EN.
module tb_shreg_ctrl;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         sel;
  logic         in_msb_first;
  logic [W-1:0] in_data;
  logic         in_valid4, in_valid1;

  logic         in_ready4, in_ready1;
  logic [1:0]   sr_s4, sr_s1;
  logic [W-1:0] sr_a4, sr_a1;
  logic         shin4, shin1;
  logic [W-1:0] q4, q1;
  logic         ser_out4, ser_out1;
  logic         ser_valid4, ser_valid1;
  logic         done4, done1;

  assign in_valid4 = in_valid & ~sel;
  assign in_valid1 = in_valid & sel;

  shreg_ctrl #(.WIDTH(W), .CLKS_PER_BIT(4), .FILL(1'b0)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_msb_first(in_msb_first), .sr_s(sr_s4), .sr_a(sr_a4),
    .sr_shift_in(shin4), .sr_q(q4), .ser_out(ser_out4), .ser_valid(ser_valid4),
    .done(done4));

  shreg_ctrl #(.WIDTH(W), .CLKS_PER_BIT(1), .FILL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_data(in_data), .in_msb_first(in_msb_first), .sr_s(sr_s1), .sr_a(sr_a1),
    .sr_shift_in(shin1), .sr_q(q1), .ser_out(ser_out1), .ser_valid(ser_valid1),
    .done(done1));

  // Behavioural 8-bit parallel-load shift registers
  always_ff @(posedge clk) begin
    if (reset) q4 <= '0;
    else case (sr_s4)
      2'b00: q4 <= sr_a4;
      2'b01: q4 <= {shin4, q4[W-1:1]};
      2'b10: q4 <= {q4[W-2:0], shin4};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) q1 <= '0;
    else case (sr_s1)
      2'b00: q1 <= sr_a1;
      2'b01: q1 <= {shin1, q1[W-1:1]};
      2'b10: q1 <= {q1[W-2:0], shin1};
      default: ;
    endcase
  end

  logic         o_rdy, o_sv, o_so, o_done;
  logic [1:0]   o_s;
  logic [W-1:0] o_a;
  always_comb begin
    if (sel) begin
      o_rdy = in_ready1; o_sv = ser_valid1; o_so = ser_out1;
      o_done = done1; o_s = sr_s1; o_a = sr_a1;
    end else begin
      o_rdy = in_ready4; o_sv = ser_valid4; o_so = ser_out4;
      o_done = done4; o_s = sr_s4; o_a = sr_a4;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int cyc,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Transmission order of the word: element k is the k-th bit on the wire
  function automatic logic [W-1:0] stream_of(input logic [W-1:0] d, input logic msb);
    logic [W-1:0] s;
    for (int k = 0; k < W; k++) s[k] = msb ? d[W-1-k] : d[k];
    return s;
  endfunction

  // One full word, checked cycle by cycle from handshake (cycle 0) to DONE.
  // Entered and left at a negedge with the selected DUT idle.
  task automatic run_word(input logic [W-1:0] data, input logic msb, input logic sel_i,
                          input logic [W-1:0] stream, input logic par, input logic hold);
    int cpb, data_end, dcyc;
    logic [1:0] shcode, exp_s;
    logic exp_sv, exp_bit;
    cpb      = sel_i ? 1 : 4;
    data_end = 2 + W * cpb;
`ifdef SHREG_CTRL_PARITY_EN
    dcyc     = data_end + cpb;
`else
    dcyc     = data_end;
`endif
    shcode       = msb ? 2'b10 : 2'b01;
    sel          = sel_i;
    in_data      = data;
    in_msb_first = msb;
    in_valid     = 1'b1;
    #1;
    check("in_ready_c0", 0, o_rdy, 1);
    for (int c = 1; c <= dcyc; c++) begin
      @(negedge clk);
      check("in_ready", c, o_rdy, 0);
      check("done", c, o_done, (c == dcyc) ? 1 : 0);
      exp_sv = (c >= 2) && (c < dcyc);
      check("ser_valid", c, o_sv, exp_sv);
      if (exp_sv) begin
        exp_bit = (c < data_end) ? stream[(c - 2) / cpb] : par;
        check("ser_out", c, o_so, exp_bit);
      end
      if (c == 1) exp_s = 2'b00;
      else if (c < data_end && ((c - 2) % cpb) == cpb - 1) exp_s = shcode;
      else exp_s = 2'b11;
      check("sr_s", c, o_s, exp_s);
      if (c == 1) begin
        check("sr_a", c, o_a, data);
        in_data      = ~data;
        in_msb_first = ~msb;
        if (!hold) in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("in_ready_after", dcyc + 1, o_rdy, 1);
    check("done_after", dcyc + 1, o_done, 0);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         msb;
    logic         sel1;
    logic [W-1:0] exp_stream;
    logic         exp_par;
  } vec_t;

  vec_t vecs[7];
  int   pulses;
  logic [W-1:0] rd;
  logic rm, rs;

  initial begin
    vecs[0] = '{8'h01, 1'b0, 1'b0, 8'h01, 1'b1};
    vecs[1] = '{8'h01, 1'b1, 1'b0, 8'h80, 1'b1};
    vecs[2] = '{8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0};
    vecs[3] = '{8'hC1, 1'b1, 1'b0, 8'h83, 1'b1};
    vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 1'b0};
    vecs[5] = '{8'h96, 1'b1, 1'b1, 8'h69, 1'b0};
    vecs[6] = '{8'h80, 1'b0, 1'b1, 8'h80, 1'b1};

    reset = 1'b1; in_valid = 1'b0; sel = 1'b0; in_data = '0; in_msb_first = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready4", 0, in_ready4, 1);
    check("rst_sr_s4", 0, sr_s4, 2'b11);
    check("rst_sr_a4", 0, sr_a4, 0);
    check("rst_shin4", 0, shin4, 0);
    check("rst_ser_out4", 0, ser_out4, 0);
    check("rst_ser_valid4", 0, ser_valid4, 0);
    check("rst_done4", 0, done4, 0);
    check("rst_in_ready1", 0, in_ready1, 1);
    check("rst_sr_s1", 0, sr_s1, 2'b11);
    check("rst_shin1", 0, shin1, 1);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_word(vecs[i].data, vecs[i].msb, vecs[i].sel1,
               vecs[i].exp_stream, vecs[i].exp_par, 1'b0);

    // in_valid held high across two back-to-back words
    run_word(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1);
    run_word(8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);

    // Reset in cycle 10 of a transfer aborts it
    sel = 1'b0; in_data = 8'hFF; in_msb_first = 1'b0; in_valid = 1'b1;
    pulses = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      pulses += int'(done4);
      if (c == 1) in_valid = 1'b0;
    end
    check("abort_busy_c10", 10, ser_valid4, 1);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 11, in_ready4, 1);
    check("abort_sr_s", 11, sr_s4, 2'b11);
    check("abort_ser_valid", 11, ser_valid4, 0);
    check("abort_sr_a", 11, sr_a4, 0);
    reset = 1'b0;
    for (int c = 12; c < 60; c++) begin
      @(negedge clk);
      pulses += int'(done4);
    end
    check("abort_no_done", 60, pulses, 0);
    check("abort_idle_ready", 60, in_ready4, 1);

    // Randomised words against the transmission-order model
    for (int n = 0; n < 12; n++) begin
      rd = W'($urandom);
      rm = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      run_word(rd, rm, rs, stream_of(rd, rm), ^rd, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
